uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx_byte transmitter between two byte requesters using round-robin arbitration. It latches the granted byte and issues a single-cycle send_go pulse. It then waits for uart_tx_done, or for a watchdog timeout, and returns a one-cycle ack to the owner. It sits between application-level byte sources (counters, status reporters) and the uart_tx_byte instance, and drives that instance's byte_in, send_go and baud_set.

Parameters:
BAUD_SET, 3'h6, baud code driven to uart_tx_byte (6 = 115200).
TIMEOUT_CYC, 20'd600000, max clk cycles spent in WAIT before aborting a transfer (exceeds one 9600-baud frame at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset; asynchronous, active-low
req0  input  1  requester 0 has a byte; level, held until ack0
data0  input  8  requester 0 byte; stable while req0 high
ack0  output  1  one-cycle pulse: requester 0 byte fully sent
req1  input  1  requester 1 request, same rules as req0
data1  input  8  requester 1 byte
ack1  output  1  one-cycle pulse: requester 1 byte fully sent
busy  output  1  high whenever state != IDLE
timeout_err  output  1  one-cycle pulse: transfer aborted by watchdog
tx_byte  output  8  to uart_tx_byte byte_in
tx_go  output  1  to uart_tx_byte send_go; single-cycle pulse
baud_set  output  3  to uart_tx_byte baud_set; constant BAUD_SET
tx_done  input  1  from uart_tx_byte uart_tx_done; one-cycle pulse at end of stop bit

Behaviour:
- Reset, asynchronous, all outputs registered:
  - state = IDLE; tx_byte = 0; tx_go, ack0, ack1, busy, timeout_err = 0.
  - rr pointer = 0, so requester 0 has priority first.
  - wdog = 0; owner = 0.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If req0 or req1 is high, grant one. Only one requesting: grant it. Both requesting: grant the one rr points to.
  - On grant: owner <= granted index; tx_byte <= granted data; go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - tx_go = 1; wdog <= 0; go to WAIT.
  - tx_go is high only in this cycle.
- WAIT:
  - wdog increments each cycle.
  - tx_done = 1: go to DONE with done_ok = 1.
  - Else if wdog == TIMEOUT_CYC-1: go to DONE with done_ok = 0.
  - tx_done and timeout in the same cycle: done wins, no error.
- DONE (exactly 1 cycle):
  - done_ok: ack[owner] = 1. Otherwise timeout_err = 1 and no ack.
  - rr <= ~owner, applied after both completion and timeout.
  - Go to IDLE.
  - No arbitration in DONE. The requester sees the ack and may drop req or present new data before IDLE samples again.
- tx_byte is held stable from LAUNCH through DONE; it changes only on a new grant.
- tx_done while in IDLE, LAUNCH or DONE is ignored.
- A requester dropping req during LAUNCH or WAIT has no effect: the transfer completes and its ack is still issued.
- Latency:
  - req sampled high in IDLE at edge k → tx_go high in cycle k+1.
  - tx_done in cycle t → ack in cycle t+1.
  - Earliest next tx_go is cycle t+3.
- Counter width: wdog is 20 bits; no wrap, since it is cleared in LAUNCH and capped at TIMEOUT_CYC-1.
- rst_n asserted mid-transfer:
  - Outputs return to reset values immediately; the pending ack is lost.
  - uart_tx_byte shares rst_n, so no partial frame continues.

Test Plan:
1. Only req0 high, data0 = 8'h55; TX model pulses tx_done 10 cycles after tx_go → exactly one tx_go with tx_byte = 8'h55, one ack0 in the cycle after tx_done, ack1 never high, busy falls after DONE.
2. req0 and req1 high from reset release, data0 = 8'hA1, data1 = 8'hB2, each re-requesting after its ack → tx_go bytes in order A1, B2, A1, B2; acks alternate ack0, ack1, ack0, ack1.
3. req0 held high, data0 incremented on each ack (00, 01, 02) → three frames carrying 00, 01, 02; each tx_go exactly 3 cycles after the preceding tx_done.
4. TIMEOUT_CYC = 100, tx_done never driven, req0 only → timeout_err pulse 101 cycles after tx_go, no ack0, next grant issued. With req1 also pending, that next grant goes to requester 1.
5. TIMEOUT_CYC = 100, tx_done driven on the final WAIT cycle (wdog = 99) → ack pulse asserted, timeout_err stays 0.
6. rst_n pulsed low mid-WAIT → all outputs 0 immediately. After release, with req1 = 1 and data1 = 8'h3C, tx_go fires with tx_byte = 8'h3C one cycle after IDLE samples req1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx_byte transmitter between two byte requesters. Requests
// are granted round-robin. The granted byte is latched onto tx_byte, a
// single-cycle tx_go pulse launches the frame, and the arbiter waits for
// tx_done. A watchdog aborts the wait if tx_done never comes. The owner then
// gets a one-cycle ack, or timeout_err pulses instead.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   req0/req1    level requests, held until the matching ack
//   data0/data1  request bytes, stable while the request is high
//   ack0/ack1    one-cycle pulse: that requester's byte was fully sent
//   busy         high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse: transfer aborted by the watchdog
//   tx_byte      byte to uart_tx_byte, held from launch through completion
//   tx_go        single-cycle send strobe to uart_tx_byte
//   baud_set     constant baud code to uart_tx_byte
//   tx_done      end-of-stop-bit pulse from uart_tx_byte
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [2:0]  BAUD_SET    = 3'h6,
    parameter logic [19:0] TIMEOUT_CYC = 20'd600000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] tx_byte,
    output logic       tx_go,
    output logic [2:0] baud_set,
    input  logic       tx_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;         // index of the requester being served
    logic        rr;            // requester favoured when both ask at once
    logic        grant_vld;
    logic        grant_idx;
    logic        done_ok_next;  // completion (1) vs watchdog abort (0)
    logic [19:0] wdog;
    logic        wdog_expired;

    assign wdog_expired = (wdog == TIMEOUT_CYC - 20'd1);
    assign baud_set     = BAUD_SET;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        grant_vld    = 1'b0;
        grant_idx    = rr;
        done_ok_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_vld  = 1'b1;
                    // A lone requester wins outright; a tie goes to rr.
                    grant_idx  = (req0 && req1) ? rr : req1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // tx_done is tested first so it beats a same-cycle timeout.
                if (tx_done) begin
                    done_ok_next = 1'b1;
                    state_next   = S_DONE;
                end else if (wdog_expired) begin
                    state_next   = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered by decoding the state being entered, so each
    // pulse lines up exactly with the cycle spent in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            tx_go       <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;
            tx_byte     <= 8'h00;
            owner       <= 1'b0;
            rr          <= 1'b0;
            wdog        <= 20'd0;
        end else begin
            busy        <= (state_next != S_IDLE);
            tx_go       <= (state_next == S_LAUNCH);
            ack0        <= (state_next == S_DONE) && done_ok_next && !owner;
            ack1        <= (state_next == S_DONE) && done_ok_next &&  owner;
            timeout_err <= (state_next == S_DONE) && !done_ok_next;

            if (grant_vld) begin
                owner   <= grant_idx;
                tx_byte <= grant_idx ? data1 : data0;
            end

            // Counting stops on the exit cycle, so wdog never passes
            // TIMEOUT_CYC-1 and cannot wrap.
            if (state == S_LAUNCH) begin
                wdog <= 20'd0;
            end else if (state == S_WAIT && state_next == S_WAIT) begin
                wdog <= wdog + 20'd1;
            end

            // Hand priority to the other requester after every transfer,
            // whether it completed or was aborted.
            if (state == S_DONE) begin
                rr <= ~owner;
            end
        end
    end

endmodule
